// File: rtl/display_scheduler_pkg.sv
// Shared types and helpers for the display scheduler.
// No logic of its own; no latency; no backpressure.
package disp_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int MAX_REQ = 8;

    function automatic logic [2:0] onehot_idx(input logic [MAX_REQ-1:0] v);
        onehot_idx = 3'd0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (v[i]) onehot_idx = 3'(i);
        end
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// Requester/display bundle: level requests and packed values in, grant/done and display value out.
// Pure wiring; no latency; requests are levels with no ready path.
interface display_scheduler_if #(
    parameter int N_REQ = 4
);
    localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]    req;
    logic [32*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    done;
    logic [31:0]         disp_val;
    logic                disp_valid;
    logic [SRC_W-1:0]    disp_src;

    modport master (
        output req, req_data,
        input  gnt, done, disp_val, disp_valid, disp_src
    );

    modport slave (
        input  req, req_data,
        output gnt, done, disp_val, disp_valid, disp_src
    );
endinterface

// File: rtl/display_scheduler_rr_arbiter.sv
// Round-robin pick: first set request scanning from ptr upward, wrapping at N_REQ.
// Combinational, zero latency; no backpressure.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int SRC_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [SRC_W-1:0] i_ptr,
    output logic             o_any,
    output logic [SRC_W-1:0] o_win
);
    always_comb begin
        o_any = 1'b0;
        o_win = '0;
        for (int i = 0; i < N_REQ; i++) begin
            int k;
            k = int'(i_ptr) + i;
            if (k >= N_REQ) k = k - N_REQ;
            if (!o_any && i_req[k]) begin
                o_any = 1'b1;
                o_win = SRC_W'(k);
            end
        end
    end
endmodule

// File: rtl/display_scheduler.sv
// Time-shares the display value among requesters, round-robin, HOLD_CYCLES per grant.
// Grant/data registered one clock after request; requesters wait at level until granted.
// DISP_SCHED_GAP_EN inserts GAP_CYCLES blank clocks after each expiry.
module display_scheduler
    import disp_sched_pkg::*;
#(
    parameter int          N_REQ       = 4,
    parameter int          HOLD_CYCLES = 50_000_000,
    parameter logic [31:0] DEFAULT_VAL = 32'h0000_0000,
    parameter int          GAP_CYCLES  = 1_000_000
) (
    input  logic                clk,
    input  logic                rst,
    display_scheduler_if.slave  sched
);
    localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = max_int(1, $clog2(max_int(HOLD_CYCLES, GAP_CYCLES)));

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [SRC_W-1:0]   r_ptr;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   r_done;
    logic [31:0]        r_val;
    logic               r_valid;
    logic [SRC_W-1:0]   r_src;

    logic               w_any;
    logic [SRC_W-1:0]   w_win;
    logic [SRC_W-1:0]   w_owner;
    logic [SRC_W-1:0]   w_ptr_nxt;
    logic [N_REQ-1:0]   w_gnt_oh;
    logic [31:0]        w_win_dat;
    logic               w_load;
    logic               w_clear;
    logic               w_expire;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    rr_arbiter #(.N_REQ(N_REQ), .SRC_W(SRC_W)) u_arb (
        .i_req (sched.req),
        .i_ptr (r_ptr),
        .o_any (w_any),
        .o_win (w_win)
    );

    assign w_owner   = SRC_W'(onehot_idx(MAX_REQ'(r_gnt)));
    assign w_ptr_nxt = (w_win == SRC_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;
    assign w_gnt_oh  = N_REQ'(1) << w_win;
    assign w_win_dat = sched.req_data[32*int'(w_win) +: 32];

    // Dropping the owner's request beats expiry, so an aborted grant never pulses done.
    always_comb begin
        w_load      = 1'b0;
        w_clear     = 1'b0;
        w_expire    = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_any) w_load = 1'b1;
            end
            SHOW: begin
                if (!sched.req[w_owner]) begin
                    w_clear     = 1'b1;
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == '0) begin
                    w_expire = 1'b1;
`ifdef DISP_SCHED_GAP_EN
                    w_clear     = 1'b1;
                    w_state_nxt = GAP;
                    w_cnt_nxt   = CNT_W'(GAP_CYCLES - 1);
`else
                    if (w_any) begin
                        w_load = 1'b1;
                    end else begin
                        w_clear     = 1'b1;
                        w_state_nxt = IDLE;
                    end
`endif
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
`ifdef DISP_SCHED_GAP_EN
            GAP: begin
                if (r_cnt == '0) begin
                    if (w_any) w_load = 1'b1;
                    else       w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
`endif
            default: begin
                w_clear     = 1'b1;
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_val   <= DEFAULT_VAL;
            r_valid <= 1'b0;
            r_src   <= '0;
        end else begin
            r_done <= w_expire ? r_gnt : '0;
            if (w_load) begin
                r_state <= SHOW;
                r_cnt   <= CNT_W'(HOLD_CYCLES - 1);
                r_ptr   <= w_ptr_nxt;
                r_gnt   <= w_gnt_oh;
                r_src   <= w_win;
                r_valid <= 1'b1;
                r_val   <= w_win_dat;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                if (w_clear) begin
                    r_gnt   <= '0;
                    r_src   <= '0;
                    r_valid <= 1'b0;
                    r_val   <= DEFAULT_VAL;
                end
            end
        end
    end

    assign sched.gnt        = r_gnt;
    assign sched.done       = r_done;
    assign sched.disp_val   = r_val;
    assign sched.disp_valid = r_valid;
    assign sched.disp_src   = r_src;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler: HOLD=4, GAP=2, N_REQ=4; follows DISP_SCHED_GAP_EN if defined.
module tb_display_scheduler;
    localparam int          N   = 4;
    localparam int          H   = 4;
    localparam int          G   = 2;
    localparam logic [31:0] DEF = 32'hDEAD_0000;
`ifdef DISP_SCHED_GAP_EN
    localparam int GAPC = G;
`else
    localparam int GAPC = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    display_scheduler_if #(.N_REQ(N)) bus();

    display_scheduler #(
        .N_REQ(N), .HOLD_CYCLES(H), .DEFAULT_VAL(DEF), .GAP_CYCLES(G)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sched (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [42:0] got, exp;
    logic [31:0] dat [N];

    // {gnt, done, valid, src, val}
    function automatic logic [42:0] pk(input logic [3:0] g, input logic [3:0] d,
                                       input logic v, input logic [1:0] s, input logic [31:0] val);
        return {g, d, v, s, val};
    endfunction

    function automatic logic [3:0] oh(input int i);
        return 4'(1) << i;
    endfunction

    task automatic set_data();
        for (int i = 0; i < N; i++) bus.req_data[32*i +: 32] = dat[i];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic sample();
        got = {bus.gnt, bus.done, bus.disp_valid, bus.disp_src, bus.disp_val};
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            sample();
            exp = pk(4'b0, 4'b0, 1'b0, 2'd0, DEF);
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset cyc%0d: got %h want %h", c, got, exp);
            end
        end
        bus.req = '0;
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        dat[2] = 32'h1234_5678;
        set_data();
        bus.req = 4'b0100;
        for (int c = 0; c < H; c++) begin
            @(negedge clk);
            sample();
            exp = pk(4'b0100, 4'b0, 1'b1, 2'd2, 32'h1234_5678);
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL single show%0d: got %h want %h", c, got, exp);
            end
        end
        for (int b = 0; b < GAPC; b++) begin
            @(negedge clk);
            sample();
            exp = pk(4'b0, (b == 0) ? 4'b0100 : 4'b0, 1'b0, 2'd0, DEF);
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL single gap%0d: got %h want %h", b, got, exp);
            end
        end
        @(negedge clk);
        sample();
        exp = pk(4'b0100, (GAPC == 0) ? 4'b0100 : 4'b0, 1'b1, 2'd2, 32'h1234_5678);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL single regrant: got %h want %h", got, exp);
        end
        bus.req = '0;
        @(negedge clk);
        sample();
        exp = pk(4'b0, 4'b0, 1'b0, 2'd0, DEF);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL single drop: got %h want %h", got, exp);
        end
    endtask

    task automatic test_round_robin();
        int order [5];
        logic [3:0] d;
        order[0] = 0; order[1] = 1; order[2] = 3; order[3] = 0; order[4] = 1;
        do_reset();
        for (int i = 0; i < N; i++) dat[i] = 32'hC0DE_0010 + 32'(i);
        set_data();
        bus.req = 4'b1011;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < H; c++) begin
                @(negedge clk);
                sample();
                d = (c == 0 && g > 0 && GAPC == 0) ? oh(order[g-1]) : 4'b0;
                exp = pk(oh(order[g]), d, 1'b1, 2'(order[g]), dat[order[g]]);
                n_chk++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL rr grant%0d cyc%0d: got %h want %h", g, c, got, exp);
                end
            end
            for (int b = 0; b < GAPC; b++) begin
                @(negedge clk);
                sample();
                exp = pk(4'b0, (b == 0) ? oh(order[g]) : 4'b0, 1'b0, 2'd0, DEF);
                n_chk++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL rr gap%0d.%0d: got %h want %h", g, b, got, exp);
                end
            end
        end
        bus.req = '0;
    endtask

    task automatic test_abort();
        do_reset();
        for (int i = 0; i < N; i++) dat[i] = 32'hAB00_0000 + 32'(i);
        set_data();
        bus.req = 4'b1010;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            sample();
            exp = pk(4'b0010, 4'b0, 1'b1, 2'd1, dat[1]);
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL abort show%0d: got %h want %h", c, got, exp);
            end
        end
        bus.req = 4'b1001;
        @(negedge clk);
        sample();
        exp = pk(4'b0, 4'b0, 1'b0, 2'd0, DEF);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL abort idle: got %h want %h", got, exp);
        end
        @(negedge clk);
        sample();
        exp = pk(4'b1000, 4'b0, 1'b1, 2'd3, dat[3]);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL abort next: got %h want %h", got, exp);
        end
        bus.req = '0;
    endtask

    task automatic test_data_latch();
        do_reset();
        dat[0] = 32'hAAAA_AAAA;
        set_data();
        bus.req = 4'b0001;
        for (int c = 0; c < H; c++) begin
            @(negedge clk);
            sample();
            exp = pk(4'b0001, 4'b0, 1'b1, 2'd0, 32'hAAAA_AAAA);
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL latch show%0d: got %h want %h", c, got, exp);
            end
            dat[0] = 32'h5555_5555;
            set_data();
        end
        for (int b = 0; b < GAPC; b++) begin
            @(negedge clk);
            sample();
            exp = pk(4'b0, (b == 0) ? 4'b0001 : 4'b0, 1'b0, 2'd0, DEF);
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL latch gap%0d: got %h want %h", b, got, exp);
            end
        end
        @(negedge clk);
        sample();
        exp = pk(4'b0001, (GAPC == 0) ? 4'b0001 : 4'b0, 1'b1, 2'd0, 32'h5555_5555);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL latch regrant: got %h want %h", got, exp);
        end
        bus.req = '0;
    endtask

    // Reset lands mid-GAP when the gap is built in, otherwise mid-SHOW.
    task automatic test_rst_mid();
        int n_show;
        n_show = (GAPC > 0) ? H : 2;
        do_reset();
        for (int i = 0; i < N; i++) dat[i] = 32'h0F0F_0000 + 32'(i);
        set_data();
        bus.req = 4'b0011;
        for (int c = 0; c < n_show; c++) begin
            @(negedge clk);
            sample();
            exp = pk(4'b0001, 4'b0, 1'b1, 2'd0, dat[0]);
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL rstmid show%0d: got %h want %h", c, got, exp);
            end
        end
        if (GAPC > 0) begin
            @(negedge clk);
            sample();
            exp = pk(4'b0, 4'b0001, 1'b0, 2'd0, DEF);
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL rstmid gap: got %h want %h", got, exp);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        sample();
        exp = pk(4'b0, 4'b0, 1'b0, 2'd0, DEF);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL rstmid reset: got %h want %h", got, exp);
        end
        rst = 1'b0;
        @(negedge clk);
        sample();
        exp = pk(4'b0001, 4'b0, 1'b1, 2'd0, dat[0]);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL rstmid ptr0: got %h want %h", got, exp);
        end
        bus.req = '0;
    endtask

    initial begin
        rst = 1'b1;
        bus.req = '0;
        bus.req_data = '0;
        for (int i = 0; i < N; i++) dat[i] = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_abort();
        test_data_latch();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
